// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_MIN_DEPTH = 2;
  localparam int FIFO_MAX_WIDTH = 64;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int fifo_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/Smemory_one_clk.sv
// Single-clock storage: one synchronous write port, one read port whose
// latency is 0 (combinational) or 1 (registered, cleared by i_rst).
module Smemory_one_clk #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int READ_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_rd
      logic unused_ctrl;
      assign unused_ctrl = i_rd_en ^ i_rst;
      assign o_rd_data   = mem_q[i_rd_addr];
    end else begin : g_reg_rd
      // Only the output register is reset; array contents survive reset.
      logic [WIDTH-1:0] rd_data_q;
      always_ff @(posedge i_clk) begin
        if (i_rst)        rd_data_q <= '0;
        else if (i_rd_en) rd_data_q <= mem_q[i_rd_addr];
      end
      assign o_rd_data = rd_data_q;
    end
  endgenerate

endmodule

// File: rtl/fifo_synchronous_param.sv
// Parameterised synchronous FIFO with registered flags and sticky errors.
// Define FIFO_SYNCHRONOUS_FWFT_EN for first-word-fall-through read behaviour.
module fifo_synchronous_param
  import fifo_pkg::*;
#(
  parameter int SIZE_DATA       = 8,
  parameter int SIZE_DEPTH      = 16,
  parameter int SIZE_ADDR       = $clog2(SIZE_DEPTH),
  parameter int ALMOST_FULL_TH  = SIZE_DEPTH - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [SIZE_DATA-1:0] i_data_wr,
  input  logic                 i_rd_en,
  output logic [SIZE_DATA-1:0] o_data_rd,
  output logic                 o_valid_rd,
  input  logic                 i_clr_err,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [SIZE_ADDR:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int PTR_W = SIZE_ADDR + 1;
  localparam int CNT_W = SIZE_ADDR + 1;

  generate
    if (SIZE_DEPTH < FIFO_MIN_DEPTH || SIZE_DATA > FIFO_MAX_WIDTH ||
        PTR_W != fifo_ptr_width(SIZE_DEPTH)) begin : g_bad_cfg
      $error("fifo_synchronous_param: unsupported SIZE_DATA/SIZE_DEPTH/SIZE_ADDR");
    end
  endgenerate

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic                 wr_acc, rd_acc;
  logic [SIZE_DATA-1:0] mem_rd_data;

  // Handshake: a read is taken when i_rd_en=1 and the FIFO is non-empty; a
  // write is taken when i_wr_en=1 and the FIFO is not full, or when a read is
  // taken in the same cycle. o_valid_rd qualifies o_data_rd: in standard mode
  // it pulses the cycle after a taken read, in FWFT mode it means "head word
  // on o_data_rd; asserting i_rd_en this cycle consumes it".
  assign o_full         = (count_q == CNT_W'(SIZE_DEPTH));
  assign o_empty        = (count_q == '0);
  assign o_almost_full  = (count_q >= CNT_W'(ALMOST_FULL_TH));
  assign o_almost_empty = (count_q <= CNT_W'(ALMOST_EMPTY_TH));
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

  assign rd_acc = i_rd_en && !o_empty;
  assign wr_acc = i_wr_en && (!o_full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new error in the clearing cycle keeps the flag set.
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (i_clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (i_wr_en && o_full && !rd_acc) ovf_d = 1'b1;
    if (i_rd_en && o_empty)           unf_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

`ifdef FIFO_SYNCHRONOUS_FWFT_EN
  localparam int RD_LAT = 0;
`else
  localparam int RD_LAT = 1;
`endif

  Smemory_one_clk #(
    .WIDTH        (SIZE_DATA),
    .DEPTH        (SIZE_DEPTH),
    .ADDR_W       (SIZE_ADDR),
    .READ_LATENCY (RD_LAT)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (wr_acc),
    .i_wr_addr (wr_ptr_q[SIZE_ADDR-1:0]),
    .i_wr_data (i_data_wr),
    .i_rd_en   (rd_acc),
    .i_rd_addr (rd_ptr_q[SIZE_ADDR-1:0]),
    .o_rd_data (mem_rd_data)
  );

`ifdef FIFO_SYNCHRONOUS_FWFT_EN
  // Head word is masked to zero while empty so reset leaves o_data_rd at 0.
  assign o_valid_rd = !o_empty;
  assign o_data_rd  = o_empty ? '0 : mem_rd_data;
`else
  logic valid_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) valid_q <= 1'b0;
    else       valid_q <= rd_acc;
  end
  assign o_valid_rd = valid_q;
  assign o_data_rd  = mem_rd_data;
`endif

endmodule

// File: tb/tb_fifo_synchronous_param.sv
// Directed scoreboard bench for fifo_synchronous_param (depth 8, 8-bit data).
module tb_fifo_synchronous_param;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_wr_en = 1'b0;
  logic [W-1:0] i_data_wr = '0;
  logic         i_rd_en = 1'b0;
  logic         i_clr_err = 1'b0;
  logic [W-1:0] o_data_rd;
  logic         o_valid_rd, o_full, o_empty, o_almost_full, o_almost_empty;
  logic [3:0]   o_count;
  logic         o_overflow, o_underflow;

  logic [W-1:0] exp_q[$];
  int           m_cnt = 0;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  fifo_synchronous_param #(
    .SIZE_DATA  (W),
    .SIZE_DEPTH (D)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_wr_en        (i_wr_en),
    .i_data_wr      (i_data_wr),
    .i_rd_en        (i_rd_en),
    .o_data_rd      (o_data_rd),
    .o_valid_rd     (o_valid_rd),
    .i_clr_err      (i_clr_err),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs just after the rising edge.
  task automatic step(input logic wr, input logic [W-1:0] d, input logic rd, input logic clr);
    bit rd_ok, wr_ok;
    @(posedge clk); #1;
    i_wr_en = wr; i_data_wr = d; i_rd_en = rd; i_clr_err = clr;
    rd_ok = rd && (m_cnt != 0);
    wr_ok = wr && ((m_cnt != D) || rd_ok);
    if (wr_ok) exp_q.push_back(d);
    m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic fill(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) step(1'b1, base + W'(i), 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic reset_now(input logic wr, input logic rd);
    @(posedge clk); #1;
    i_rst = 1'b1; i_wr_en = wr; i_rd_en = rd; i_data_wr = 8'h99; i_clr_err = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_data_wr = '0;
    exp_q.delete();
    m_cnt = 0;
  endtask

  // Monitor: pops the expected queue whenever the DUT delivers a word.
  always @(negedge clk) begin
    if (!i_rst) begin
`ifdef FIFO_SYNCHRONOUS_FWFT_EN
      if (o_valid_rd && i_rd_en) begin
`else
      if (o_valid_rd) begin
`endif
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_data: got 0x%0h, expected no word", o_data_rd);
        end else begin
          chk("rd_data", 32'(o_data_rd), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    sample();
    chk("rst_count", 32'(o_count), 0);
    chk("rst_empty", 32'(o_empty), 1);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_aempty", 32'(o_almost_empty), 1);
    chk("rst_afull", 32'(o_almost_full), 0);
    chk("rst_valid", 32'(o_valid_rd), 0);
    chk("rst_data", 32'(o_data_rd), 0);
    chk("rst_ovf", 32'(o_overflow), 0);
    chk("rst_unf", 32'(o_underflow), 0);

    // Fill to full, drain in order
    fill(8'h01, 8); idle(); sample();
    chk("fill_full", 32'(o_full), 1);
    chk("fill_count", 32'(o_count), 8);
    chk("fill_afull", 32'(o_almost_full), 1);
    drain(8); idle(); sample();
    chk("drain_empty", 32'(o_empty), 1);
    chk("drain_count", 32'(o_count), 0);

    // Overflow: ninth write is dropped, then cleared
    fill(8'h11, 8);
    step(1'b1, 8'hAA, 1'b0, 1'b0); idle(); sample();
    chk("ovf_set", 32'(o_overflow), 1);
    chk("ovf_count", 32'(o_count), 8);
    step(1'b0, '0, 1'b0, 1'b1); idle(); sample();
    chk("ovf_clr", 32'(o_overflow), 0);
    drain(8); idle(); sample();
    chk("ovf_drain_empty", 32'(o_empty), 1);

    // Underflow, then read+write on empty
    step(1'b0, '0, 1'b1, 1'b0); idle(); sample();
    chk("unf_set", 32'(o_underflow), 1);
    chk("unf_valid", 32'(o_valid_rd), 0);
`ifdef FIFO_SYNCHRONOUS_FWFT_EN
    chk("unf_data", 32'(o_data_rd), 32'h00);
`else
    chk("unf_data_held", 32'(o_data_rd), 32'h18);
`endif
    step(1'b0, '0, 1'b0, 1'b1); idle(); sample();
    chk("unf_clr", 32'(o_underflow), 0);
    step(1'b1, 8'h33, 1'b1, 1'b0); idle(); sample();
    chk("rdwr_empty_count", 32'(o_count), 1);
    chk("rdwr_empty_unf", 32'(o_underflow), 1);
    drain(1);
    step(1'b0, '0, 1'b0, 1'b1); idle(); sample();
    chk("rdwr_empty_drained", 32'(o_count), 0);

    // Full plus simultaneous read/write: 0x55 comes out eighth
    fill(8'h21, 8);
    step(1'b1, 8'h55, 1'b1, 1'b0); idle(); sample();
    chk("full_rdwr_count", 32'(o_count), 8);
    chk("full_rdwr_ovf", 32'(o_overflow), 0);
    drain(8); idle(); sample();
    chk("full_rdwr_empty", 32'(o_empty), 1);

    // Pointer wrap with threshold flags at counts 6 and 2
    fill(8'h41, 6); idle(); sample();
    chk("th6_count", 32'(o_count), 6);
    chk("th6_afull", 32'(o_almost_full), 1);
    chk("th6_aempty", 32'(o_almost_empty), 0);
    drain(1); idle(); sample();
    chk("th5_afull", 32'(o_almost_full), 0);
    drain(2); idle(); sample();
    chk("th3_aempty", 32'(o_almost_empty), 0);
    drain(1); idle(); sample();
    chk("th2_count", 32'(o_count), 2);
    chk("th2_aempty", 32'(o_almost_empty), 1);
    for (int i = 0; i < 14; i++) step(1'b1, 8'h50 + W'(i), 1'b1, 1'b0);
    idle(); sample();
    chk("wrap_count", 32'(o_count), 2);
    drain(2); idle(); sample();
    chk("wrap_empty", 32'(o_empty), 1);

    // Reset mid-stream with count 5
    fill(8'h61, 5); idle(); sample();
    chk("mid_count5", 32'(o_count), 5);
    reset_now(1'b1, 1'b1);
    sample();
    chk("mid_rst_count", 32'(o_count), 0);
    chk("mid_rst_empty", 32'(o_empty), 1);
    chk("mid_rst_valid", 32'(o_valid_rd), 0);
    chk("mid_rst_data", 32'(o_data_rd), 0);
    fill(8'h77, 2);
    drain(2); idle(); idle(); sample();
    chk("post_rst_empty", 32'(o_count), 0);
    chk("sb_leftover", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_synchronous_param.md
FIFO_SYNCHRONOUS_PARAM -- requirements
Module: fifo_synchronous_param

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8: data word width in bits, 1..64.
REQ-002 SHALL have parameter SIZE_DEPTH, default 16: word capacity; power of two, at least 2.
REQ-003 SHALL have parameter SIZE_ADDR, default $clog2(SIZE_DEPTH): memory address width.
REQ-004 SHALL have parameter ALMOST_FULL_TH, default SIZE_DEPTH-2: o_almost_full asserts when count >= this value.
REQ-005 SHALL have parameter ALMOST_EMPTY_TH, default 2: o_almost_empty asserts when count <= this value.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port i_wr_en, input, 1 bit: write request.
REQ-009 SHALL have port i_data_wr, input, SIZE_DATA bits: write data.
REQ-010 SHALL have port i_rd_en, input, 1 bit: read/pop request.
REQ-011 SHALL have port o_data_rd, output, SIZE_DATA bits: read data.
REQ-012 SHALL have port o_valid_rd, output, 1 bit: o_data_rd valid qualifier.
REQ-013 SHALL have port i_clr_err, input, 1 bit: clears the sticky error flags.
REQ-014 SHALL have port o_full, output, 1 bit, and port o_empty, output, 1 bit.
REQ-015 SHALL have port o_almost_full, output, 1 bit, and port o_almost_empty, output, 1 bit.
REQ-016 SHALL have port o_count, output, SIZE_ADDR+1 bits: occupancy, 0..SIZE_DEPTH.
REQ-017 SHALL have port o_overflow, output, 1 bit, and port o_underflow, output, 1 bit: sticky error flags.

Function
REQ-018 SHALL accept a write when i_wr_en=1 and (o_full=0 or a read is accepted in the same cycle).
REQ-019 SHALL accept a read when i_rd_en=1 and o_empty=0; a read on empty SHALL be ignored even if a write is accepted in the same cycle.
REQ-020 SHALL use SIZE_ADDR+1-bit read and write pointers that wrap modulo 2*SIZE_DEPTH; the memory index is the low SIZE_ADDR bits.
REQ-021 SHALL derive flags from the registered count: o_full = (count==SIZE_DEPTH), o_empty = (count==0), threshold flags per REQ-004/005.
REQ-022 SHALL update the count as follows: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write or no accepted operation.
REQ-023 SHALL update all flags and o_count in the cycle after the accepting edge, with no combinational path from inputs to flags.
REQ-024 SHALL set o_overflow on i_wr_en=1 while full with no accepted read; the write is dropped and memory and pointers are unchanged.
REQ-025 SHALL set o_underflow on i_rd_en=1 while empty; o_data_rd is unchanged.
REQ-026 SHALL clear the error flags on i_clr_err=1 at the next edge; if a new error occurs in the same cycle, the set SHALL win.
REQ-027 SHALL return words in write order across pointer wrap-around, with no loss or duplication.

Reset
REQ-028 SHALL, while i_rst=1 at a clock edge, clear both pointers and the count and drive o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0, o_valid_rd=0, o_overflow=0, o_underflow=0, o_data_rd=0, o_count=0.
REQ-029 SHALL make reset take priority over any concurrent read or write, abandoning in-flight data; memory contents are not cleared.

Configuration
REQ-030 SHALL use macro FIFO_SYNCHRONOUS_FWFT_EN to select first-word-fall-through mode.
REQ-031 SHALL, when FIFO_SYNCHRONOUS_FWFT_EN is undefined, operate in standard mode: o_data_rd is registered one cycle after the accepted read, and o_valid_rd pulses for exactly that cycle.
REQ-032 SHALL, when FIFO_SYNCHRONOUS_FWFT_EN is defined, operate in FWFT mode: o_data_rd presents the head word whenever non-empty, o_valid_rd = !o_empty, i_rd_en pops the head, and the next word appears at the next edge.
REQ-033 SHALL give a word written into an empty FIFO in FWFT mode 1-cycle visibility latency, identical to the count update.

Structure
REQ-034 SHALL place shared constants (minimum depth, maximum width) and the pointer-width function in the shared package fifo_pkg.
REQ-035 SHALL instantiate storage as a single sub-module, Smemory_one_clk: one write port and one read port, with a synchronous write and a read whose latency is selectable.

Verification
REQ-036 SHALL cover this case with DEPTH=8: write 0x01..0x08 -> o_full=1 and o_count=8; then read 8 times -> data 0x01..0x08 in order, and o_empty=1.
REQ-037 SHALL cover this case: full FIFO plus a 9th write 0xAA -> o_overflow=1, o_count stays 8, and 0xAA is never read; then i_clr_err -> o_overflow=0.
REQ-038 SHALL cover this case: empty FIFO plus i_rd_en -> o_underflow=1 and o_valid_rd=0; simultaneous rd+wr on empty -> write accepted and o_count=1.
REQ-039 SHALL cover this case: full FIFO plus simultaneous rd+wr 0x55 -> o_count stays 8, and 0x55 emerges after 7 further reads.
REQ-040 SHALL cover this case: 20 writes interleaved with reads to wrap pointers twice -> data order preserved, and o_almost_full/o_almost_empty toggle at counts 6 and 2.
REQ-041 SHALL cover this case: i_rst asserted mid-stream with count=5 -> the next cycle shows o_count=0 and o_empty=1; this runs in both FWFT and standard builds.
